// File: rtl/breadboard_sweep_ctrl_if.sv
// Result stream from the sweep sequencer: one captured Breadboard result per
// transfer. A transfer happens on a rising edge where out_valid & out_ready.
// Once raised, out_valid stays high and out_idx/out_data stay stable until
// that transfer.
interface breadboard_sweep_ctrl_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_idx;
  logic [9:0] out_data;

  modport master (output out_valid, output out_idx, output out_data, input out_ready);
  modport slave  (input out_valid, input out_idx, input out_data, output out_ready);
endinterface

// File: rtl/breadboard_sweep_ctrl.sv
// Hardware sequencer for the 4-input Breadboard block: drives each vector,
// waits SETTLE cycles, captures r, streams it out and folds it into a signature.
module breadboard_sweep_ctrl #(
  parameter int SETTLE = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           single,
  input  logic [3:0]                     vec_in,
  output logic                           w,
  output logic                           x,
  output logic                           y,
  output logic                           z,
  input  logic [9:0]                     r,
  breadboard_sweep_ctrl_if.master        bus,
  output logic                           busy,
  output logic                           done,
  output logic [9:0]                     sig,
  output logic [1:0]                     state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] idx;
  logic       single_q;
  logic [7:0] cnt;
  logic [3:0] idx_q;
  logic [9:0] data_q;
  logic       settle_last;
  logic       xfer;
  logic       last_vec;

  assign settle_last = (cnt == CNT_LAST);
  assign xfer        = (state == S_EMIT) && bus.out_ready;
  assign last_vec    = single_q || (idx == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    {w, x, y, z}  = idx;
    case (state)
      S_IDLE: begin
        busy         = 1'b0;
        {w, x, y, z} = 4'h0;
        if (start) state_nxt = S_DRIVE;
      end
      S_DRIVE: begin
        if (settle_last) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        bus.out_valid = 1'b1;
        if (xfer) state_nxt = last_vec ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: idx, settle counter, capture registers and signature.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= 4'h0;
      single_q <= 1'b0;
      cnt      <= 8'd0;
      idx_q    <= 4'h0;
      data_q   <= 10'h000;
      sig      <= 10'h000;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            single_q <= single;
            idx      <= single ? vec_in : 4'h0;
            cnt      <= 8'd0;
            sig      <= 10'h000;
          end
        end
        S_DRIVE: begin
          if (settle_last) begin
            data_q <= r;
            idx_q  <= idx;
            cnt    <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_EMIT: begin
          if (xfer) begin
            sig <= {sig[8:0], sig[9]} ^ data_q;
            // Sweep stops at 15 rather than wrapping back to 0.
            if (!last_vec) idx <= idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_idx  = idx_q;
  assign bus.out_data = data_q;
  assign state_dbg    = state;

endmodule

// File: doc/breadboard_sweep_ctrl.md
# breadboard_sweep_ctrl

Sequencer that exhaustively exercises the 4-input `Breadboard` function block in hardware rather than in a testbench loop. On `start` it walks the input vector `{w,x,y,z}` through 0..15, or applies one selected vector. After a programmable settle time it captures the ten outputs `r0..r9` and hands each result downstream over a valid/ready stream. It also folds every transferred result into a running 10-bit signature for quick pass/fail comparison.

## Interface
Parameters:
- `SETTLE`, default 1: cycles each vector is held on `w,x,y,z` before capture; legal range 1..255.

Ports:
- `clk`, input, 1: single clock; all state updates on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin an operation; sampled only in IDLE.
- `single`, input, 1: sampled with `start`. 1 = apply only `vec_in`; 0 = full sweep 0..15.
- `vec_in`, input, 4: vector used when `single`=1, sampled with `start`.
- `w`, `x`, `y`, `z`, output, 1 each: drive the Breadboard inputs. Mapping: `w`=idx[3], `x`=idx[2], `y`=idx[1], `z`=idx[0].
- `r`, input, 10: Breadboard outputs; `r[i]` = `ri`.
- `out_valid`, output, 1: captured result available.
- `out_ready`, input, 1: consumer accepts the result.
- `out_idx`, output, 4: vector index of the result.
- `out_data`, output, 10: captured `r`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse at the end of an operation.
- `sig`, output, 10: running signature.

## Operation
- FSM states:
  - IDLE: `busy`=0; `start`=1 latches `single`/`vec_in`, clears `sig`, sets idx (0, or `vec_in` if single), and goes to DRIVE.
  - DRIVE: `w,x,y,z` = idx; settle counter counts SETTLE cycles. On the last cycle, `r` is registered into `out_data`, idx into `out_idx`, and the FSM goes to EMIT.
  - EMIT: `out_valid`=1; `out_data`/`out_idx` held stable until handshake. On `out_valid & out_ready`:
    - `sig` ← {sig[8:0],sig[9]} ^ out_data.
    - If single, or idx==15, go to DONE; otherwise idx ← idx+1 and go to DRIVE.
  - DONE: `done`=1 for exactly one cycle, then IDLE. `sig` holds until the next `start` or `rst`.
- `w,x,y,z` keep driving idx in EMIT and DONE, and return to 0 in IDLE.
- idx is 4 bits. The sweep terminates on idx==15 and never wraps to 0.
- `start` while busy is ignored; it is neither queued nor able to restart the operation.
- `out_ready` high while `out_valid`=0 has no effect.
- `rst` at any time, including mid-sweep or mid-handshake, returns to IDLE within the same edge and aborts with no `done` pulse.
- Reset values: state IDLE, `w,x,y,z`=0, `out_valid`=0, `out_idx`=0, `out_data`=0, `busy`=0, `done`=0, `sig`=0, settle counter 0.
- The Breadboard is combinational, so no capture is taken before SETTLE cycles have elapsed.

## Timing
- `start` sampled at edge E0: `busy` and the vector are valid after E0.
- Capture occurs at edge E0+SETTLE; `out_valid` is high after that edge.
- With `out_ready` held high, each vector costs SETTLE+1 cycles.
- Full sweep: final handshake at E0+16·(SETTLE+1); `done` high for the following cycle; IDLE after the next edge.
- With SETTLE=1 this is 32 cycles to the final transfer.
- Single mode: `done` high in the cycle after edge E0+SETTLE+1 when `out_ready` is held high.
- Backpressure: each cycle with `out_ready`=0 in EMIT adds exactly one cycle; there is no data loss or duplication.
- `start` sampled in the same cycle that DONE returns to IDLE is not accepted; `start` is accepted from the first IDLE cycle onward.

## Test plan
- Reset then full sweep, SETTLE=1, `out_ready`=1:
  - 16 transfers with idx 0..15 in order.
  - idx 0 → `out_data`=10'h020 (r5 only).
  - idx 15 → `out_data`=10'h11F.
  - `done` pulses once in the cycle after edge 32.
  - `sig` equals the model-computed rotate-XOR over all 16 results.
- Single mode, `vec_in`=4'hF, SETTLE=3:
  - Exactly one transfer, `out_idx`=15, `out_data`=10'h11F.
  - `out_valid` rises after edge E0+3.
  - `done` pulses once.
  - `sig`=10'h11F.
- Backpressure: `out_ready` random at 50% over a full sweep.
  - `out_data`/`out_idx` stable while stalled.
  - Still exactly 16 ordered transfers and the same `sig` as the first test.
- `start` pulsed repeatedly during a sweep:
  - No restart and no extra transfers.
  - A `start` issued one cycle after `done` begins a new sweep with `sig` cleared to 0.
- `rst` asserted in EMIT at idx 7 with `out_ready`=0:
  - Next cycle: IDLE, `out_valid`=0, `busy`=0, `sig`=0, `w,x,y,z`=0.
  - No `done` pulse.
  - A subsequent `start` sweeps from idx 0.
